// File: rtl/mul_issue_scheduler_pkg.sv
// Shared types and default sizing for the multiply/ALU issue scheduler.
package mul_issue_scheduler_pkg;

  localparam int MUL_LAT_DEF = 5;
  localparam int ALU_LAT_DEF = 1;
  localparam int REG_W_DEF   = 5;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] rd;
  } mul_sb_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mul_scoreboard.sv
// In-flight multiply tracker: entry k holds the multiply issued k+1 cycles ago.
module mul_scoreboard #(
  parameter int DEPTH = 5,
  parameter int REG_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        clear,
  input  logic                        ins_valid,
  input  logic [REG_W-1:0]            ins_rd,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH-1:0][REG_W-1:0] ent_rd
);

  // Clear beats stall so a kill always empties the pipe at the sampling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid <= '0;
      ent_rd    <= '0;
    end else if (clear) begin
      ent_valid <= '0;
      ent_rd    <= '0;
    end else if (!stall) begin
      ent_valid <= {ent_valid[DEPTH-2:0], ins_valid};
      ent_rd    <= {ent_rd[DEPTH-2:0], ins_rd};
    end
  end

endmodule

// File: rtl/mul_issue_scheduler.sv
// Issue controller routing decoded ops to the pipelined multiplier or the ALU,
// holding issue on scoreboard hazards and sequencing fence drains / kill flushes.
module mul_issue_scheduler
  import mul_issue_scheduler_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic                         dec_is_m,
  input  logic [REG_W-1:0]             dec_rd,
  input  logic [REG_W-1:0]             dec_rs1,
  input  logic [REG_W-1:0]             dec_rs2,
  output logic                         dec_ready,
  input  logic                         fence_req,
  output logic                         fence_done,
  input  logic                         kill,
  input  logic                         stall_in,
  output logic                         mul_issue,
  output logic                         alu_issue,
  output logic                         stall_mul,
  output logic                         kill_mul,
  output logic                         wb_sel,
  output logic [REG_W-1:0]             wb_rd,
  output logic [$clog2(MUL_LAT+1)-1:0] mul_inflight,
  output logic [CNT_W-1:0]             hazard_cycles
);

  localparam int IW = $clog2(MUL_LAT+1);

  sched_state_t                  state;
  logic [MUL_LAT-1:0]            ent_valid;
  logic [MUL_LAT-1:0][REG_W-1:0] ent_rd;
  logic                          raw_hit;
  logic                          waw_hit;
  logic                          port_hit;
  logic                          hazard;
  logic                          in_run;

  mul_scoreboard #(
    .DEPTH (MUL_LAT),
    .REG_W (REG_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall_in),
    .clear     (kill),
    .ins_valid (mul_issue),
    .ins_rd    (dec_rd),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // The entry writing back this cycle is still checked: there is no bypass.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) begin
      if (ent_valid[k] && ent_rd[k] != '0) begin
        if (dec_rs1 != '0 && dec_rs1 == ent_rd[k]) raw_hit = 1'b1;
        if (dec_rs2 != '0 && dec_rs2 == ent_rd[k]) raw_hit = 1'b1;
        if (dec_rd  != '0 && dec_rd  == ent_rd[k]) waw_hit = 1'b1;
      end
    end
  end

  // An ALU op issued now writes back together with this entry's multiply.
  assign port_hit = !dec_is_m && dec_rd != '0 && ent_valid[MUL_LAT-1-ALU_LAT];
  assign hazard   = raw_hit | waw_hit | port_hit;

  always_comb begin
    mul_inflight = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      mul_inflight = mul_inflight + IW'(ent_valid[k]);
    end
  end

  assign in_run     = (state == RUN);
  assign dec_ready  = dec_valid & in_run & !fence_req & !hazard & !stall_in & !kill;
  assign mul_issue  = dec_ready & dec_is_m;
  assign alu_issue  = dec_ready & !dec_is_m;
  assign stall_mul  = stall_in;
  assign wb_sel     = ent_valid[MUL_LAT-1];
  assign wb_rd      = ent_valid[MUL_LAT-1] ? ent_rd[MUL_LAT-1] : '0;
  assign fence_done = (state == DRAIN) && (mul_inflight == '0) && !kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      kill_mul      <= 1'b0;
      hazard_cycles <= '0;
    end else begin
      kill_mul <= kill;
      if (dec_valid && in_run && hazard && !kill && hazard_cycles != '1) begin
        hazard_cycles <= hazard_cycles + 1'b1;
      end
      case (state)
        RUN: begin
          if (kill)           state <= FLUSH;
          else if (fence_req) state <= DRAIN;
        end
        DRAIN: begin
          if (kill)                     state <= FLUSH;
          else if (mul_inflight == '0)  state <= RUN;
        end
        FLUSH: begin
          state <= kill ? FLUSH : RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
